// File: rtl/conv_window_sched.sv
// Load/scan controller for a multi-port convolution window buffer: writes one image
// row-major, then presents every KSIZE x KSIZE window as PORT_NUM packed read addresses.
module conv_window_sched #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int KSIZE      = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              wr_en,
    output logic [ADDR_WIDTH-1:0]             wr_addr_1P,
    output logic [KSIZE*KSIZE*ADDR_WIDTH-1:0] rd_addr_NP,
    output logic                              win_valid,
    input  logic                              win_ready,
    output logic [15:0]                       win_row,
    output logic [15:0]                       win_col,
    output logic                              busy,
    output logic                              done,
    output logic [2:0]                        state_dbg
);
    localparam int PORT_NUM = KSIZE * KSIZE;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int IW       = $clog2(NPIX) + 1;
    localparam int SW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [15:0]   COL_MAX  = 16'(IMG_W - KSIZE);
    localparam logic [15:0]   ROW_MAX  = 16'(IMG_H - KSIZE);
    localparam logic [IW-1:0] LAST_PIX = IW'(NPIX - 1);

    generate
        if (KSIZE > IMG_W || KSIZE > IMG_H) begin : g_bad_ksize
            $error("conv_window_sched: KSIZE must not exceed IMG_W or IMG_H");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // With zero read latency the addresses are valid as soon as they are registered.
    localparam state_t SCAN_ENTRY = (RD_LAT == 0) ? S_PRESENT : S_SETTLE;

    state_t                         state;
    logic [IW-1:0]                  ld_cnt;
    logic [SW-1:0]                  settle_cnt;
    logic [15:0]                    row, col;
    logic [15:0]                    row_nxt, col_nxt;
    logic                           last_win;
    logic [IW-1:0]                  base;
    logic [PORT_NUM*ADDR_WIDTH-1:0] rd_addr_q, rd_addr_nxt;

    // Handshake: a pixel is written when in_valid & in_ready; a window is accepted
    // when win_valid & win_ready, and win_valid never falls without an acceptance.
    assign in_ready   = (state == S_LOAD);
    assign wr_en      = in_valid & in_ready;
    assign wr_addr_1P = ADDR_WIDTH'(ld_cnt);
    assign rd_addr_NP = rd_addr_q;
    assign win_valid  = (state == S_PRESENT);
    assign win_row    = row;
    assign win_col    = col;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign state_dbg  = state;

    always_comb begin
        row_nxt  = row;
        col_nxt  = col;
        last_win = 1'b0;
        if (state == S_LOAD) begin
            row_nxt = '0;
            col_nxt = '0;
        end else if (col < COL_MAX) begin
            col_nxt = col + 16'd1;
        end else if (row < ROW_MAX) begin
            row_nxt = row + 16'd1;
            col_nxt = '0;
        end else begin
            last_win = 1'b1;
        end
    end

    always_comb begin
        base        = IW'(row_nxt) * IW'(IMG_W) + IW'(col_nxt);
        rd_addr_nxt = '0;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                rd_addr_nxt[(i*KSIZE+j)*ADDR_WIDTH +: ADDR_WIDTH] =
                    ADDR_WIDTH'(base + IW'(i*IMG_W + j));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ld_cnt     <= '0;
            settle_cnt <= '0;
            row        <= '0;
            col        <= '0;
            rd_addr_q  <= '0;
        end else if (abort) begin
            state      <= S_IDLE;
            ld_cnt     <= '0;
            settle_cnt <= '0;
            row        <= '0;
            col        <= '0;
            rd_addr_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_LOAD;
                        ld_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (ld_cnt == LAST_PIX) begin
                            state      <= SCAN_ENTRY;
                            row        <= row_nxt;
                            col        <= col_nxt;
                            rd_addr_q  <= rd_addr_nxt;
                            settle_cnt <= '0;
                        end else begin
                            ld_cnt <= ld_cnt + IW'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SW'(RD_LAT - 1)) begin
                        state <= S_PRESENT;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                S_PRESENT: begin
                    if (win_ready) begin
                        if (last_win) begin
                            state <= S_DONE;
                        end else begin
                            state      <= SCAN_ENTRY;
                            row        <= row_nxt;
                            col        <= col_nxt;
                            rd_addr_q  <= rd_addr_nxt;
                            settle_cnt <= '0;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: 8x6 image / 3x3 kernel / RD_LAT=1, plus a
// 3x3 image / 3x3 kernel / RD_LAT=0 instance for the single-window case.
`timescale 1ns/1ps
module tb_conv_window_sched;
    localparam int AW = 32;
    localparam int KS = 3;
    localparam int NP = KS * KS;
    localparam int W  = 8;
    localparam int H  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, abort, in_valid, win_ready;
    logic           in_ready, wr_en, win_valid, busy, done;
    logic [AW-1:0]    wr_addr_1P;
    logic [NP*AW-1:0] rd_addr_NP;
    logic [15:0]    win_row, win_col;
    logic [2:0]     state_dbg;

    logic           s_start, s_in_valid, s_win_ready;
    logic           s_in_ready, s_wr_en, s_win_valid, s_busy, s_done;
    logic [AW-1:0]    s_wr_addr;
    logic [NP*AW-1:0] s_rd_addr;
    logic [15:0]    s_win_row, s_win_col;
    logic [2:0]     s_state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    conv_window_sched #(
        .IMG_W(W), .IMG_H(H), .KSIZE(KS), .ADDR_WIDTH(AW), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
        .wr_addr_1P(wr_addr_1P), .rd_addr_NP(rd_addr_NP),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    conv_window_sched #(
        .IMG_W(3), .IMG_H(3), .KSIZE(3), .ADDR_WIDTH(AW), .RD_LAT(0)
    ) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .abort(abort),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .wr_en(s_wr_en),
        .wr_addr_1P(s_wr_addr), .rd_addr_NP(s_rd_addr),
        .win_valid(s_win_valid), .win_ready(s_win_ready),
        .win_row(s_win_row), .win_col(s_win_col),
        .busy(s_busy), .done(s_done), .state_dbg(s_state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] port_of(input logic [NP*AW-1:0] v, input int k);
        return v[k*AW +: AW];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_flags"}, {in_ready, wr_en, win_valid, busy, done}, 0);
        check({tag, "_wr_addr"}, wr_addr_1P, 0);
        check({tag, "_rd_addr"}, rd_addr_NP, 0);
        check({tag, "_row_col"}, {win_row, win_col}, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    task automatic load_image(input bit gaps, input string tag);
        int  exp_a = 0;
        int  cyc = 0;
        int  writes = 0;
        bit  w;
        while (exp_a < W*H && cyc < 500) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check({tag, "_wr_en"}, wr_en, in_valid);
            check({tag, "_wr_addr"}, wr_addr_1P, exp_a);
            w = wr_en;
            tick();
            cyc++;
            if (w) begin
                exp_a++;
                writes++;
            end
        end
        in_valid = 1'b0;
        check({tag, "_writes"}, writes, W*H);
        if (!gaps) check({tag, "_cycles"}, cyc, W*H);
        check({tag, "_in_ready_after"}, in_ready, 0);
    endtask

    task automatic run_scan(input bit use_bp, input string tag);
        int r = 0;
        int c = 0;
        int n_win = 0;
        int cyc = 0;
        int last_acc = 0;
        int holds = 0;
        bit fin = 1'b0;
        logic [NP*AW-1:0] held;
        logic [NP*AW-1:0] exp_vec;
        held = '0;
        while (!fin && cyc < 300) begin
            win_ready = !(use_bp && win_valid && r == 2 && c == 2 && holds < 5);
            #1;
            check({tag, "_no_done"}, done, 0);
            if (win_valid) begin
                for (int k = 0; k < NP; k++)
                    exp_vec[k*AW +: AW] = AW'((r + k / KS) * W + c + k % KS);
                check({tag, "_row"}, win_row, r);
                check({tag, "_col"}, win_col, c);
                check({tag, "_ports"}, rd_addr_NP, exp_vec);
                if (!win_ready) begin
                    if (holds == 0) held = rd_addr_NP;
                    else check({tag, "_hold_stable"}, rd_addr_NP, held);
                    check({tag, "_hold_port4"}, port_of(rd_addr_NP, 4), 27);
                    holds++;
                end else begin
                    if (n_win > 0 && !use_bp) check({tag, "_gap"}, cyc - last_acc, 2);
                    if (r == 0 && c == 0) begin
                        check({tag, "_w00_p0"}, port_of(rd_addr_NP, 0), 0);
                        check({tag, "_w00_p8"}, port_of(rd_addr_NP, 8), 18);
                    end
                    if (r == 1 && c == 5) begin
                        check({tag, "_w15_p0"}, port_of(rd_addr_NP, 0), 13);
                        check({tag, "_w15_p8"}, port_of(rd_addr_NP, 8), 31);
                    end
                    if (r == 3 && c == 5) begin
                        check({tag, "_w35_p0"}, port_of(rd_addr_NP, 0), 29);
                        check({tag, "_w35_p8"}, port_of(rd_addr_NP, 8), 47);
                    end
                    last_acc = cyc;
                    n_win++;
                    if (c < W - KS) c++;
                    else if (r < H - KS) begin
                        r++;
                        c = 0;
                    end else fin = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        win_ready = 1'b0;
        check({tag, "_windows"}, n_win, 24);
        if (use_bp) check({tag, "_holds"}, holds, 5);
        check({tag, "_done_pulse"}, {done, busy}, 2'b11);
        tick();
        check({tag, "_done_end"}, {done, busy}, 2'b00);
        check({tag, "_rd_retained"}, port_of(rd_addr_NP, 0), 29);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; win_ready = 1'b0;
        s_start = 1'b0; s_in_valid = 1'b0; s_win_ready = 1'b0;

        // Reset and idle, with start asserted while reset is held.
        tick();
        start = 1'b1;
        tick();
        check_idle("start_in_rst");
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_idle("idle");
        end

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("abort_beats_start");

        // Full load, unthrottled scan.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load1_entry", {in_ready, busy, state_dbg}, {1'b1, 1'b1, 3'd1});
        load_image(1'b0, "load1");
        run_scan(1'b0, "scan1");

        // Load with random gaps, scan with backpressure on window (2,2).
        start = 1'b1;
        tick();
        start = 1'b0;
        load_image(1'b1, "load2");
        run_scan(1'b1, "scan2");

        // Abort in LOAD at address 20.
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        repeat (20) tick();
        check("abort_load_addr", wr_addr_1P, 20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        check_idle("abort_load");

        // Reload from 0, then abort while presenting window (1,3).
        start = 1'b1;
        tick();
        start = 1'b0;
        check("reload_addr", {in_ready, wr_addr_1P}, {1'b1, 32'd0});
        load_image(1'b0, "load3");
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            win_ready = 1'b1;
            #1;
            if (win_valid && win_row == 16'd1 && win_col == 16'd3) begin
                win_ready = 1'b0;
                found = 1'b1;
            end else begin
                tick();
            end
        end
        check("reach_w13", found, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_present");

        // Asynchronous reset in the middle of a load.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("reload2_addr", {in_ready, wr_addr_1P}, {1'b1, 32'd0});
        in_valid = 1'b1;
        repeat (3) tick();
        check("pre_rst_addr", wr_addr_1P, 3);
        rst = 1'b1;
        #1;
        check_idle("rst_mid");
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        check_idle("after_rst_mid");

        // Single-window instance with zero read latency.
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("s_entry", {s_in_ready, s_busy}, 2'b11);
        s_in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            check("s_wr", {s_wr_en, s_wr_addr}, {1'b1, 32'(i)});
            tick();
        end
        s_in_valid = 1'b0;
        check("s_present", {s_win_valid, s_win_row, s_win_col}, {1'b1, 16'd0, 16'd0});
        for (int k = 0; k < NP; k++)
            check($sformatf("s_port%0d", k), port_of(s_rd_addr, k), k);
        tick();
        check("s_hold_valid", s_win_valid, 1);
        check("s_hold_port8", port_of(s_rd_addr, 8), 8);
        s_win_ready = 1'b1;
        tick();
        s_win_ready = 1'b0;
        check("s_done", {s_done, s_win_valid}, 2'b10);
        tick();
        check("s_idle", {s_done, s_busy, s_state_dbg}, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
